// File: rtl/il1_fill_controller.sv
// L1 instruction-store fill engine: fetches one aligned block from the next
// memory level word by word and writes each returned word into the L1 store.
module il1_fill_controller #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MEM_ADDR_W  = 16,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_valid,
    input  logic [MEM_ADDR_W-1:0] miss_addr,
    output logic                  miss_ready,
    output logic                  mem_req,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  l1_mode,
    output logic [ADDR_W-1:0]     l1_write_address,
    output logic [DATA_W-1:0]     l1_write_value,
    output logic                  busy,
    output logic                  fill_done
);

    localparam int unsigned OFFSET_W = $clog2(BLOCK_WORDS);
    localparam int unsigned COUNT_W  = OFFSET_W + 1;

    // Clears the in-block offset bits of the missing address.
    localparam logic [MEM_ADDR_W-1:0] ALIGN_MASK = ~MEM_ADDR_W'(BLOCK_WORDS - 1);
    localparam logic [COUNT_W-1:0]    LAST_COUNT = COUNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } fillState_t;

    fillState_t              stateQ;
    fillState_t              stateD;
    logic [MEM_ADDR_W-1:0]   baseQ;
    logic [MEM_ADDR_W-1:0]   baseD;
    logic [COUNT_W-1:0]      countQ;
    logic [COUNT_W-1:0]      countD;
    logic [DATA_W-1:0]       dataQ;
    logic [DATA_W-1:0]       dataD;
    logic [MEM_ADDR_W-1:0]   wordAddr;

    // Base is aligned, so adding the in-block count never carries out.
    assign wordAddr = baseQ + MEM_ADDR_W'(countQ);

    // State and datapath registers; reset aborts any fill in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= IDLE;
            baseQ  <= '0;
            countQ <= '0;
            dataQ  <= '0;
        end else begin
            stateQ <= stateD;
            baseQ  <= baseD;
            countQ <= countD;
            dataQ  <= dataD;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        stateD           = stateQ;
        baseD            = baseQ;
        countD           = countQ;
        dataD            = dataQ;
        miss_ready       = 1'b0;
        mem_req          = 1'b0;
        mem_addr         = '0;
        l1_mode          = 1'b0;
        l1_write_address = '0;
        l1_write_value   = '0;
        busy             = 1'b0;
        fill_done        = 1'b0;

        unique case (stateQ)
            IDLE: begin
                // Held low while reset is asserted so every output reads 0.
                miss_ready = ~reset;
                if (miss_valid) begin
                    baseD  = miss_addr & ALIGN_MASK;
                    countD = '0;
                    stateD = REQ;
                end
            end

            REQ: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = wordAddr;
                if (mem_ack) begin
                    dataD  = mem_rdata;
                    stateD = WRITE;
                end
            end

            WRITE: begin
                busy             = 1'b1;
                l1_mode          = 1'b1;
                l1_write_address = ADDR_W'(wordAddr);
                l1_write_value   = dataQ;
                if (countQ == LAST_COUNT) begin
                    stateD = DONE;
                end else begin
                    countD = countQ + COUNT_W'(1);
                    stateD = REQ;
                end
            end

            DONE: begin
                busy      = 1'b1;
                fill_done = 1'b1;
                stateD    = IDLE;
            end

            default: begin
                stateD = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_il1_fill_controller.sv
// Scoreboard bench for il1_fill_controller: stimulus queues expected L1
// writes, memory requests and fill_done cycles; a monitor checks them.
module tb_il1_fill_controller;

    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned MEM_ADDR_W  = 16;
    localparam int unsigned BLOCK_WORDS = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  miss_valid = 1'b0;
    logic [MEM_ADDR_W-1:0] miss_addr = '0;
    logic                  miss_ready;
    logic                  mem_req;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic                  mem_ack = 1'b0;
    logic [DATA_W-1:0]     mem_rdata = '0;
    logic                  l1_mode;
    logic [ADDR_W-1:0]     l1_write_address;
    logic [DATA_W-1:0]     l1_write_value;
    logic                  busy;
    logic                  fill_done;

    il1_fill_controller #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MEM_ADDR_W  (MEM_ADDR_W),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .miss_valid       (miss_valid),
        .miss_addr        (miss_addr),
        .miss_ready       (miss_ready),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .l1_mode          (l1_mode),
        .l1_write_address (l1_write_address),
        .l1_write_value   (l1_write_value),
        .busy             (busy),
        .fill_done        (fill_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] value;
    } wr_t;

    typedef struct {
        logic [MEM_ADDR_W-1:0] addr;
        int                    len;   // expected REQ cycles; 0 = aborted, unchecked
    } req_t;

    wr_t  wrQ[$];
    req_t reqQ[$];
    int   doneQ[$];

    int nTests = 0;
    int nFails = 0;
    int cycle = 0;
    int writeCount = 0;

    logic                  spuriousAck = 1'b0;
    logic [MEM_ADDR_W-1:0] stallAddr = 16'hFFFF;
    int                    stallLen = 0;
    int                    waitCnt = 0;

    logic                  inRun = 1'b0;
    logic [MEM_ADDR_W-1:0] runAddr = '0;
    int                    runLen = 0;
    int                    expLen = 0;
    wr_t                   wrExp;
    req_t                  reqExp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
        wr_t w;
        w.addr  = a;
        w.value = v;
        wrQ.push_back(w);
    endtask

    task automatic pushReq(input logic [MEM_ADDR_W-1:0] a, input int len);
        req_t r;
        r.addr = a;
        r.len  = len;
        reqQ.push_back(r);
    endtask

    // Issue a miss and hold miss_valid until accepted. Cycle T+n is the
    // period following edge T+n-1, so fill_done in cycle T+lat is seen at
    // the monitor with cycle == T+lat-1. lat=0 means no fill_done expected.
    task automatic doFill(input logic [MEM_ADDR_W-1:0] addr, input int lat);
        bit accepted;
        accepted = 1'b0;
        @(negedge clk);
        miss_addr  = addr;
        miss_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (miss_ready) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            if (lat > 0) doneQ.push_back(cycle + 1 + lat - 1);
            @(posedge clk);
            #1;
        end
        miss_valid = 1'b0;
        miss_addr  = '0;
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) check("idle_timeout", 64'd0, 64'd1);
    endtask

    // Edge counter used to time fill_done.
    always @(posedge clk) cycle <= cycle + 1;

    // Next-level memory model: answers with address XOR 0xA5A5, optionally
    // stalling one address, optionally raising a stray ack during WRITE.
    always @(negedge clk) begin
        if (reset) begin
            mem_ack = 1'b0;
            waitCnt = 0;
        end else if (mem_req) begin
            if (mem_addr == stallAddr && waitCnt < stallLen) begin
                mem_ack = 1'b0;
                waitCnt++;
            end else begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr ^ 16'hA5A5;
                waitCnt   = 0;
            end
        end else begin
            waitCnt   = 0;
            mem_ack   = spuriousAck && l1_mode;
            mem_rdata = (spuriousAck && l1_mode) ? 16'hDEAD : 16'h0000;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a write, a
    // request or a done pulse, and checks idle outputs are zero.
    always @(negedge clk) begin
        if (reset) begin
            inRun = 1'b0;
        end else begin
            if (l1_mode) begin
                writeCount++;
                if (wrQ.size() == 0) begin
                    check("unexpected_l1_write", 64'd1, 64'd0);
                end else begin
                    wrExp = wrQ.pop_front();
                    check("l1_write_address", 64'(l1_write_address), 64'(wrExp.addr));
                    check("l1_write_value", 64'(l1_write_value), 64'(wrExp.value));
                end
            end else begin
                check("l1_idle_zero", 64'({l1_write_address, l1_write_value}), 64'd0);
            end

            if (mem_req && !inRun) begin
                if (reqQ.size() == 0) begin
                    check("unexpected_mem_req", 64'd1, 64'd0);
                    expLen = 0;
                end else begin
                    reqExp = reqQ.pop_front();
                    check("mem_addr", 64'(mem_addr), 64'(reqExp.addr));
                    expLen = reqExp.len;
                end
                inRun   = 1'b1;
                runAddr = mem_addr;
                runLen  = 1;
            end else if (mem_req && inRun) begin
                runLen++;
                check("mem_addr_stable", 64'(mem_addr), 64'(runAddr));
            end else begin
                check("mem_addr_idle_zero", 64'(mem_addr), 64'd0);
                if (inRun) begin
                    inRun = 1'b0;
                    if (expLen != 0) check("mem_req_cycles", 64'(runLen), 64'(expLen));
                end
            end

            if (fill_done) begin
                if (doneQ.size() == 0) check("unexpected_fill_done", 64'd1, 64'd0);
                else check("fill_done_cycle", 64'(cycle), 64'(doneQ.pop_front()));
            end
        end
    end

    // Directed test sequence.
    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs_zero",
              64'({miss_ready, mem_req, mem_addr, l1_mode, l1_write_address,
                   l1_write_value, busy, fill_done}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("release_miss_ready", 64'(miss_ready), 64'd1);
        check("release_busy", 64'(busy), 64'd0);

        // Basic fill, immediate ack.
        pushReq(16'h0044, 1); pushReq(16'h0045, 1); pushReq(16'h0046, 1); pushReq(16'h0047, 1);
        pushWrite(5'd4, 16'hA5E1); pushWrite(5'd5, 16'hA5E0);
        pushWrite(5'd6, 16'hA5E3); pushWrite(5'd7, 16'hA5E2);
        doFill(16'h0046, 9);
        waitIdle();

        // Three-cycle ack stall on word 1.
        stallAddr = 16'h0045;
        stallLen  = 3;
        pushReq(16'h0044, 1); pushReq(16'h0045, 4); pushReq(16'h0046, 1); pushReq(16'h0047, 1);
        pushWrite(5'd4, 16'hA5E1); pushWrite(5'd5, 16'hA5E0);
        pushWrite(5'd6, 16'hA5E3); pushWrite(5'd7, 16'hA5E2);
        doFill(16'h0046, 12);
        waitIdle();
        stallAddr = 16'hFFFF;
        stallLen  = 0;

        // L1 address at the top of the store.
        pushReq(16'h013C, 1); pushReq(16'h013D, 1); pushReq(16'h013E, 1); pushReq(16'h013F, 1);
        pushWrite(5'd28, 16'hA499); pushWrite(5'd29, 16'hA498);
        pushWrite(5'd30, 16'hA49B); pushWrite(5'd31, 16'hA49A);
        doFill(16'h013E, 9);
        waitIdle();

        // Wrap back to entry 0, with stray acks during every WRITE.
        spuriousAck = 1'b1;
        pushReq(16'h0020, 1); pushReq(16'h0021, 1); pushReq(16'h0022, 1); pushReq(16'h0023, 1);
        pushWrite(5'd0, 16'hA585); pushWrite(5'd1, 16'hA584);
        pushWrite(5'd2, 16'hA587); pushWrite(5'd3, 16'hA586);
        doFill(16'h0020, 9);
        waitIdle();
        spuriousAck = 1'b0;

        // miss_valid pulsed mid-fill must not start a second fill.
        pushReq(16'h0088, 1); pushReq(16'h0089, 1); pushReq(16'h008A, 1); pushReq(16'h008B, 1);
        pushWrite(5'd8, 16'hA52D); pushWrite(5'd9, 16'hA52C);
        pushWrite(5'd10, 16'hA52F); pushWrite(5'd11, 16'hA52E);
        doFill(16'h0089, 9);
        repeat (3) @(negedge clk);
        miss_addr  = 16'h0100;
        miss_valid = 1'b1;
        @(negedge clk);
        miss_valid = 1'b0;
        miss_addr  = '0;
        waitIdle();
        repeat (6) @(negedge clk);
        check("no_second_fill_busy", 64'(busy), 64'd0);

        // Reset asserted mid-cycle during the third word's REQ.
        stallAddr = 16'h0012;
        stallLen  = 20;
        pushReq(16'h0010, 1); pushReq(16'h0011, 1); pushReq(16'h0012, 0);
        pushWrite(5'd16, 16'hA5B5); pushWrite(5'd17, 16'hA5B4);
        doFill(16'h0010, 0);
        begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (mem_req && mem_addr == 16'h0012) begin
                    found = 1'b1;
                    break;
                end
            end
            check("third_word_req_seen", 64'(found), 64'd1);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs_zero",
              64'({miss_ready, mem_req, mem_addr, l1_mode, l1_write_address,
                   l1_write_value, busy, fill_done}), 64'd0);
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        stallAddr = 16'hFFFF;
        stallLen  = 0;
        #1;
        check("rerelease_miss_ready", 64'(miss_ready), 64'd1);
        check("rerelease_busy", 64'(busy), 64'd0);

        // Fresh fill after the aborted one.
        pushReq(16'h0008, 1); pushReq(16'h0009, 1); pushReq(16'h000A, 1); pushReq(16'h000B, 1);
        pushWrite(5'd8, 16'hA5AD); pushWrite(5'd9, 16'hA5AC);
        pushWrite(5'd10, 16'hA5AF); pushWrite(5'd11, 16'hA5AE);
        doFill(16'h0008, 9);
        waitIdle();

        repeat (4) @(negedge clk);
        check("pending_writes", 64'(wrQ.size()), 64'd0);
        check("pending_reqs", 64'(reqQ.size()), 64'd0);
        check("pending_done", 64'(doneQ.size()), 64'd0);
        check("total_l1_writes", 64'(writeCount), 64'd26);

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

    // Hard stop if the run wedges.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected finish before 200000");
        $fatal(1);
    end

endmodule
